// File: rtl/pe_result_drain.sv
// pe_result_drain
//
// Output stage behind the NxN systolic PE array. On the rising edge of
// finish_flag the full result matrix on c_bus is captured into a local
// buffer and streamed out one word per cycle in row-major order. The array
// may start its next matrix while the previous result is still draining.
//
// Ports:
//   clk          rising-edge clock
//   rst          synchronous, active-high reset
//   finish_flag  completion level from the array (c_bus valid while high)
//   c_bus        flattened results, element (i,j) at [(N*i+j)*W +: W]
//   out_ready    consumer accepts the current word
//   out_valid    out_data/out_row/out_col/out_last hold a valid word
//   out_data     result word
//   out_row      row index of out_data
//   out_col      column index of out_data
//   out_last     high with element (N-1,N-1)
//   busy         high while draining
//   overrun      sticky: a completion arrived mid-drain and was dropped
//   state_dbg    current FSM state (0 = IDLE, 1 = DRAIN)
//
// Handshake: a beat transfers on a rising clk edge where out_valid and
// out_ready are both high. out_valid never depends on out_ready in the same
// cycle, and once raised the word and indices hold steady until accepted.

module pe_result_drain #(
    parameter int N = 8,
    parameter int W = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 finish_flag,
    input  logic [N*N*W-1:0]     c_bus,
    input  logic                 out_ready,
    output logic                 out_valid,
    output logic [W-1:0]         out_data,
    output logic [$clog2(N)-1:0] out_row,
    output logic [$clog2(N)-1:0] out_col,
    output logic                 out_last,
    output logic                 busy,
    output logic                 overrun,
    output logic                 state_dbg
);

    localparam int NE    = N * N;
    localparam int IDX_W = $clog2(NE);
    localparam int RC_W  = $clog2(N);

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_DRAIN = 1'b1
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic             finish_q;
    logic [IDX_W-1:0] idx_q;
    logic             overrun_q;
    logic [W-1:0]     res_buf [NE];

    logic start;
    logic beat;
    logic at_last;
    logic last_beat;
    logic capture;

    assign start     = finish_flag & ~finish_q;
    assign beat      = (state_q == S_DRAIN) & out_ready;
    assign at_last   = (idx_q == IDX_W'(NE - 1));
    assign last_beat = beat & at_last;
    // A new result is taken when idle, or in the very cycle the final word
    // leaves, which lets back-to-back matrices stream without a bubble.
    assign capture   = start & ((state_q == S_IDLE) | last_beat);

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (last_beat && !start) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Edge detector, element counter and sticky overrun flag
    always_ff @(posedge clk) begin
        if (rst) begin
            finish_q  <= 1'b0;
            idx_q     <= '0;
            overrun_q <= 1'b0;
        end else begin
            finish_q <= finish_flag;
            if (capture) begin
                idx_q <= '0;
            end else if (beat && !at_last) begin
                idx_q <= idx_q + 1'b1;
            end
            if (start && !capture) begin
                overrun_q <= 1'b1;
            end
        end
    end

    // Capture buffer: contents are don't-care until the first capture.
    always_ff @(posedge clk) begin
        if (capture) begin
            for (int k = 0; k < NE; k++) begin
                res_buf[k] <= c_bus[k*W +: W];
            end
        end
    end

    // Outputs: everything is forced to zero outside DRAIN so the idle and
    // post-reset values are all zero without extra registers.
    always_comb begin
        out_valid = (state_q == S_DRAIN);
        busy      = (state_q == S_DRAIN);
        out_data  = '0;
        out_row   = '0;
        out_col   = '0;
        out_last  = 1'b0;
        if (state_q == S_DRAIN) begin
            out_data = res_buf[idx_q];
            out_row  = idx_q[IDX_W-1 -: RC_W];
            out_col  = idx_q[RC_W-1:0];
            out_last = at_last;
        end
        overrun   = overrun_q;
        state_dbg = state_q;
    end

endmodule

// File: tb/tb_pe_result_drain.sv
// Testbench for pe_result_drain: randomized and directed stimulus, a
// behavioural model that turns each accepted completion into 64 expected
// beats on a queue, and a negedge monitor that pops and compares.

module tb_pe_result_drain;

    localparam int N  = 8;
    localparam int W  = 32;
    localparam int NE = N * N;
    localparam int EW = W + 3 + 3 + 1;

    logic             clk;
    logic             rst;
    logic             finish_flag;
    logic [N*N*W-1:0] c_bus;
    logic             out_ready;
    logic             out_valid;
    logic [W-1:0]     out_data;
    logic [2:0]       out_row;
    logic [2:0]       out_col;
    logic             out_last;
    logic             busy;
    logic             overrun;
    logic             state_dbg;

    pe_result_drain #(.N(N), .W(W)) dut (
        .clk         (clk),
        .rst         (rst),
        .finish_flag (finish_flag),
        .c_bus       (c_bus),
        .out_ready   (out_ready),
        .out_valid   (out_valid),
        .out_data    (out_data),
        .out_row     (out_row),
        .out_col     (out_col),
        .out_last    (out_last),
        .busy        (busy),
        .overrun     (overrun),
        .state_dbg   (state_dbg)
    );

    // ---------------- clock ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- scoreboard state ----------------
    logic [EW-1:0] exp_q[$];
    logic [W-1:0]  mat [NE];
    int            model_left;
    logic          exp_ovr;
    logic          prev_f;
    int            check_cnt;
    int            pass_cnt;

    task automatic check(input string name, input logic ok,
                         input logic [63:0] act, input logic [63:0] exp);
        check_cnt++;
        if (ok) pass_cnt++;
        else $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    endtask

    // ---------------- driver ----------------
    // Applies one cycle of inputs, advances the reference model for the
    // coming edge, then checks the status outputs just after that edge.
    task automatic drive(input logic f, input logic r, input logic rs);
        logic acc;
        finish_flag = f;
        out_ready   = r;
        rst         = rs;
        for (int k = 0; k < NE; k++) c_bus[k*W +: W] = mat[k];
        if (rs) begin
            exp_q.delete();
            model_left = 0;
            exp_ovr    = 1'b0;
            prev_f     = 1'b0;
        end else begin
            acc = (model_left > 0) && r;
            if (acc) model_left--;
            if (f && !prev_f) begin
                if (model_left == 0) begin
                    for (int k = 0; k < NE; k++)
                        exp_q.push_back({mat[k], 3'(k / N), 3'(k % N), (k == NE - 1)});
                    model_left = NE;
                end else begin
                    exp_ovr = 1'b1;
                end
            end
            prev_f = f;
        end
        @(posedge clk);
        #1;
        check("out_valid", out_valid == (model_left > 0), 64'(out_valid), 64'(model_left > 0));
        check("busy", busy == (model_left > 0), 64'(busy), 64'(model_left > 0));
        check("overrun", overrun == exp_ovr, 64'(overrun), 64'(exp_ovr));
        if (model_left == 0)
            check("idle_zero", {out_data, out_row, out_col, out_last} == '0,
                  64'({out_data, out_row, out_col, out_last}), 64'd0);
    endtask

    task automatic idle_run(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 1'b1, 1'b0);
    endtask

    task automatic load_pattern();
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++)
                mat[N*i+j] = (32'(i) << 28) | (32'(j) << 24) + 32'(8*i + j);
    endtask

    // ---------------- monitor ----------------
    logic          stall_prev;
    logic [EW-1:0] held;

    always @(negedge clk) begin
        logic [EW-1:0] cur;
        logic [EW-1:0] exp;
        cur = {out_data, out_row, out_col, out_last};
        if (rst) begin
            stall_prev = 1'b0;
        end else begin
            if (stall_prev)
                check("stall_stable", out_valid && cur == held, 64'(cur), 64'(held));
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_beat", 1'b0, 64'(cur), 64'd0);
                end else begin
                    exp = exp_q.pop_front();
                    check("beat", cur == exp, 64'(cur), 64'(exp));
                end
            end
            stall_prev = out_valid && !out_ready;
            held       = cur;
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        check_cnt  = 0;
        pass_cnt   = 0;
        model_left = 0;
        exp_ovr    = 1'b0;
        prev_f     = 1'b0;
        stall_prev = 1'b0;
        held       = '0;
        for (int k = 0; k < NE; k++) mat[k] = '0;

        // reset
        for (int i = 0; i < 3; i++) drive(1'b0, 1'b0, 1'b1);
        idle_run(2);

        // basic drain, ready held high
        load_pattern();
        drive(1'b1, 1'b1, 1'b0);
        idle_run(70);

        // backpressure: ready 1,0,0,1
        drive(1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 140; i++) drive(1'b0, (i % 4 == 0) || (i % 4 == 3), 1'b0);
        idle_run(4);

        // level-held finish_flag, random ready
        for (int i = 0; i < NE; i++) mat[i] = $urandom;
        for (int i = 0; i < 200; i++) drive(1'b1, $urandom_range(0, 3) != 0, 1'b0);
        idle_run(4);

        // seamless chain at the last beat
        load_pattern();
        drive(1'b1, 1'b1, 1'b0);
        for (int i = 0; i < NE - 1; i++) drive(1'b0, 1'b1, 1'b0);
        for (int k = 0; k < NE; k++) mat[k] = 32'hA5A5_0000 + 32'(k);
        drive(1'b1, 1'b1, 1'b0);
        check("chain_head", {out_data, out_row, out_col} == {32'hA5A5_0000, 6'd0},
              64'({out_data, out_row, out_col}), 64'({32'hA5A5_0000, 6'd0}));
        idle_run(70);

        // overrun at beat 10
        load_pattern();
        drive(1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 10; i++) drive(1'b0, 1'b1, 1'b0);
        for (int k = 0; k < NE; k++) mat[k] = 32'hFFFF_FFFF;
        drive(1'b1, 1'b1, 1'b0);
        idle_run(60);
        drive(1'b0, 1'b0, 1'b1);
        idle_run(2);

        // reset mid-drain at beat 20, then restart
        load_pattern();
        drive(1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 20; i++) drive(1'b0, 1'b1, 1'b0);
        drive(1'b0, 1'b0, 1'b1);
        idle_run(3);
        drive(1'b1, 1'b1, 1'b0);
        idle_run(70);

        // random traffic with random completions
        for (int i = 0; i < 800; i++) begin
            logic f;
            f = ($urandom_range(0, 59) == 0);
            if (f) for (int k = 0; k < NE; k++) mat[k] = $urandom;
            drive(f, $urandom_range(0, 3) != 0, 1'b0);
        end
        idle_run(80);
        check("queue_drained", exp_q.size() == 0, 64'(exp_q.size()), 64'd0);

        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule
